fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the RV64I five-stage pipeline; sits directly upstream of `decode`. It owns the PC and issues requests to instruction memory over a req/ack handshake. It presents `{pc, instr, valid}` to decode, honours decode's hazard stall, and takes branch/jump redirects from execute, squashing any wrong-path fetch.

---
 rtl/fetch.sv | 164 ++++++++++++++++
 tb/tb_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - RV64I instruction-fetch stage with IF/ID pipeline register
module fetch #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_o_req,
   output logic [63:0] imem_o_addr,
   input  logic        imem_i_ack,
   input  logic [31:0] imem_i_rdata,
   input  logic        ctrl_i_stall_D,
   input  logic        ctrl_i_redirect,
   input  logic [63:0] ctrl_i_redirect_pc,
   output logic [63:0] regD_o_pc,
   output logic [31:0] regD_o_instr,
   output logic        regD_o_valid
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_WAIT_D = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t      state_q, state_n;
   logic [63:0] pc_q, pc_n;
   logic [63:0] addr_q, addr_n;
   logic [63:0] d_pc_q, d_pc_n;
   logic [31:0] d_instr_q, d_instr_n;
   logic        d_valid_q, d_valid_n;
   logic [63:0] buf_pc_q, buf_pc_n;
   logic [31:0] buf_instr_q, buf_instr_n;
   logic        buf_valid_q, buf_valid_n;

   logic        xfer;
   logic [63:0] target;
   logic        unused_redirect_lsbs;

   assign imem_o_req  = !rst && (state_q != ST_WAIT_D);
   assign imem_o_addr = addr_q;
   assign xfer        = imem_o_req && imem_i_ack;
   assign target      = {ctrl_i_redirect_pc[63:2], 2'b00};

   assign unused_redirect_lsbs = ^ctrl_i_redirect_pc[1:0];

   assign regD_o_pc    = d_pc_q;
   assign regD_o_instr = d_instr_q;
   assign regD_o_valid = d_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         d_pc_q      <= 64'd0;
         d_instr_q   <= NOP_INSTR;
         d_valid_q   <= 1'b0;
         buf_pc_q    <= 64'd0;
         buf_instr_q <= NOP_INSTR;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         pc_q        <= pc_n;
         addr_q      <= addr_n;
         d_pc_q      <= d_pc_n;
         d_instr_q   <= d_instr_n;
         d_valid_q   <= d_valid_n;
         buf_pc_q    <= buf_pc_n;
         buf_instr_q <= buf_instr_n;
         buf_valid_q <= buf_valid_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      pc_n        = pc_q;
      addr_n      = addr_q;
      d_pc_n      = d_pc_q;
      d_instr_n   = d_instr_q;
      d_valid_n   = d_valid_q;
      buf_pc_n    = buf_pc_q;
      buf_instr_n = buf_instr_q;
      buf_valid_n = buf_valid_q;

      if (ctrl_i_redirect) begin
         // Redirect wins over stall: anything fetched so far is wrong-path.
         pc_n        = target;
         d_instr_n   = NOP_INSTR;
         d_valid_n   = 1'b0;
         buf_valid_n = 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (xfer) begin
                  addr_n = target;
               end else begin
                  state_n = ST_FLUSH;
               end
            end
            ST_WAIT_D: begin
               addr_n  = target;
               state_n = ST_FETCH;
            end
            ST_FLUSH: begin
               if (xfer) begin
                  addr_n  = target;
                  state_n = ST_FETCH;
               end
            end
            default: begin
               addr_n  = target;
               state_n = ST_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (xfer && !ctrl_i_stall_D) begin
                  d_pc_n    = addr_q;
                  d_instr_n = imem_i_rdata;
                  d_valid_n = 1'b1;
                  pc_n      = addr_q + 64'd4;
                  addr_n    = addr_q + 64'd4;
               end else if (xfer) begin
                  buf_pc_n    = addr_q;
                  buf_instr_n = imem_i_rdata;
                  buf_valid_n = 1'b1;
                  state_n     = ST_WAIT_D;
               end else if (!ctrl_i_stall_D) begin
                  d_instr_n = NOP_INSTR;
                  d_valid_n = 1'b0;
               end
            end
            ST_WAIT_D: begin
               if (!ctrl_i_stall_D) begin
                  d_pc_n      = buf_pc_q;
                  d_instr_n   = buf_instr_q;
                  d_valid_n   = buf_valid_q;
                  buf_valid_n = 1'b0;
                  pc_n        = buf_pc_q + 64'd4;
                  addr_n      = buf_pc_q + 64'd4;
                  state_n     = ST_FETCH;
               end
            end
            ST_FLUSH: begin
               // The returning word belongs to the abandoned path; only the handshake matters.
               if (!ctrl_i_stall_D) begin
                  d_instr_n = NOP_INSTR;
                  d_valid_n = 1'b0;
               end
               if (xfer) begin
                  addr_n  = pc_q;
                  state_n = ST_FETCH;
               end
            end
            default: begin
               addr_n  = pc_q;
               state_n = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - scoreboard bench for fetch against a program-order reference model
module tb_fetch;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          NCYC   = 4000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_o_req;
   logic [63:0] imem_o_addr;
   logic        imem_i_ack;
   logic [31:0] imem_i_rdata;
   logic        ctrl_i_stall_D;
   logic        ctrl_i_redirect;
   logic [63:0] ctrl_i_redirect_pc;
   logic [63:0] regD_o_pc;
   logic [31:0] regD_o_instr;
   logic        regD_o_valid;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk                (clk),
      .rst                (rst),
      .imem_o_req         (imem_o_req),
      .imem_o_addr        (imem_o_addr),
      .imem_i_ack         (imem_i_ack),
      .imem_i_rdata       (imem_i_rdata),
      .ctrl_i_stall_D     (ctrl_i_stall_D),
      .ctrl_i_redirect    (ctrl_i_redirect),
      .ctrl_i_redirect_pc (ctrl_i_redirect_pc),
      .regD_o_pc          (regD_o_pc),
      .regD_o_instr       (regD_o_instr),
      .regD_o_valid       (regD_o_valid)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          consumed = 0;
   logic [63:0] exp_fetch_pc;
   bit          discard_pending;
   bit          useful;
   logic [63:0] useful_addr;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
   endfunction

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Driver: memory responder, decode/execute stimulus, and expected-stream generation.
   initial begin
      int ack_pct, stall_pct;
      rst = 1'b1; imem_i_ack = 1'b0; imem_i_rdata = 32'd0;
      ctrl_i_stall_D = 1'b0; ctrl_i_redirect = 1'b0; ctrl_i_redirect_pc = 64'd0;
      exp_fetch_pc = RST_PC; discard_pending = 0; useful = 0; useful_addr = 64'd0;
      for (int i = 0; i < NCYC; i++) begin
         @(posedge clk); #1;
         rst = 1'b0; ctrl_i_stall_D = 1'b0; ctrl_i_redirect = 1'b0;
         ctrl_i_redirect_pc = 64'd0; imem_i_ack = 1'b0;
         if (i < 3) rst = 1'b1;
         else if (i < 25) imem_i_ack = 1'b1;
         else if (i < 45) imem_i_ack = (i % 3 == 0);
         else if (i < 65) begin
            imem_i_ack = 1'b1;
            ctrl_i_stall_D = (i >= 50 && i < 53);
         end else if (i == 65) begin
            ctrl_i_redirect = 1'b1; ctrl_i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9; imem_i_ack = 1'b1;
         end else if (i < 80) imem_i_ack = 1'b1;
         else if (i == 80) begin
            ctrl_i_redirect = 1'b1; ctrl_i_redirect_pc = 64'h0000_0000_8000_0101;
         end else if (i < 83) imem_i_ack = 1'b0;
         else if (i < 98) imem_i_ack = 1'b1;
         else if (i < 100) begin
            ctrl_i_stall_D = 1'b1; imem_i_ack = 1'b1;
         end else if (i == 100) begin
            ctrl_i_stall_D = 1'b1; ctrl_i_redirect = 1'b1; ctrl_i_redirect_pc = 64'h0000_0000_0000_1000;
         end else if (i < 120) imem_i_ack = 1'b1;
         else begin
            case ((i >> 8) % 4)
               0: begin ack_pct = 100; stall_pct = 0;  end
               1: begin ack_pct = 50;  stall_pct = 30; end
               2: begin ack_pct = 20;  stall_pct = 60; end
               default: begin ack_pct = 80; stall_pct = 10; end
            endcase
            imem_i_ack     = ($urandom_range(0, 99) < ack_pct);
            ctrl_i_stall_D = ($urandom_range(0, 99) < stall_pct);
            ctrl_i_redirect = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0)
               ctrl_i_redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            else
               ctrl_i_redirect_pc = {$urandom(), $urandom()};
            rst = ($urandom_range(0, 199) == 0);
         end
         imem_i_rdata = imem_i_ack ? mem_word(imem_o_addr) : 32'hDEAD_BEEF;
         #1;
         useful = 0;
         if (rst) begin
            exp_q.delete();
            exp_fetch_pc = RST_PC;
            discard_pending = 0;
         end else if (ctrl_i_redirect) begin
            exp_q.delete();
            exp_fetch_pc = {ctrl_i_redirect_pc[63:2], 2'b00};
            discard_pending = imem_o_req && !imem_i_ack;
         end else if (imem_o_req && imem_i_ack) begin
            if (discard_pending) discard_pending = 0;
            else begin
               check(imem_o_addr == exp_fetch_pc, "fetch_addr", imem_o_addr, exp_fetch_pc);
               exp_q.push_back('{pc: imem_o_addr, instr: imem_i_rdata});
               useful = 1;
               useful_addr = imem_o_addr;
               exp_fetch_pc = exp_fetch_pc + 64'd4;
            end
         end
      end
      @(negedge clk); #1;
      check(consumed > 500, "consumed_count", 64'(consumed), 64'd500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Monitor: decode-side consumption against the scoreboard, plus cycle properties.
   bit          have_prev = 0;
   bit          wait_d = 0;
   logic [63:0] buf_addr_m = 64'd0;
   bit          p_rst, p_redirect, p_stall, p_useful, p_wait, p_req, p_ack, p_valid;
   logic [63:0] p_uaddr, p_pc, p_addr;
   logic [31:0] p_instr;

   always @(negedge clk) begin
      ent_t e;
      if (have_prev) begin
         check(imem_o_addr[1:0] == 2'b00, "addr_align", imem_o_addr, {imem_o_addr[63:2], 2'b00});
         if (rst) check(imem_o_req == 1'b0, "req_in_reset", 64'(imem_o_req), 64'd0);
         else     check(imem_o_req == !wait_d, "req_state", 64'(imem_o_req), 64'(!wait_d));
         if (p_rst) begin
            check(regD_o_valid == 1'b0, "rst_valid", 64'(regD_o_valid), 64'd0);
            check(regD_o_instr == NOP, "rst_instr", 64'(regD_o_instr), 64'(NOP));
            check(regD_o_pc == 64'd0, "rst_pc", regD_o_pc, 64'd0);
            check(imem_o_addr == RST_PC, "rst_addr", imem_o_addr, RST_PC);
         end else begin
            if (p_redirect)
               check(!regD_o_valid && regD_o_instr == NOP, "redirect_bubble", {regD_o_valid, regD_o_instr}, {1'b0, NOP});
            else if (p_useful && !p_stall)
               check(regD_o_valid && regD_o_pc == p_uaddr && regD_o_instr == mem_word(p_uaddr),
                     "latency_pc", regD_o_valid ? regD_o_pc : 64'hX, p_uaddr);
            else if (p_wait && !p_stall)
               check(regD_o_valid && regD_o_pc == buf_addr_m, "release_pc",
                     regD_o_valid ? regD_o_pc : 64'hX, buf_addr_m);
            else if (p_stall)
               check(regD_o_valid == p_valid && regD_o_pc == p_pc && regD_o_instr == p_instr,
                     "stall_hold", {regD_o_valid, regD_o_instr}, {p_valid, p_instr});
            else
               check(regD_o_valid == 1'b0, "no_ack_bubble", 64'(regD_o_valid), 64'd0);
            if (p_req && !p_ack)
               check(imem_o_addr == p_addr, "addr_stable", imem_o_addr, p_addr);
         end
         if (!regD_o_valid) check(regD_o_instr == NOP, "bubble_nop", 64'(regD_o_instr), 64'(NOP));
         if (!rst && !ctrl_i_redirect && !ctrl_i_stall_D && regD_o_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_underflow: got pc %h with nothing expected", regD_o_pc);
            end else begin
               e = exp_q.pop_front();
               check(regD_o_pc == e.pc, "sb_pc", regD_o_pc, e.pc);
               check(regD_o_instr == e.instr, "sb_instr", 64'(regD_o_instr), 64'(e.instr));
               consumed++;
            end
         end
      end
      if (!rst && !ctrl_i_redirect && !wait_d && useful && ctrl_i_stall_D) buf_addr_m = useful_addr;
      p_wait     = wait_d;
      wait_d     = rst ? 1'b0 : ctrl_i_redirect ? 1'b0 : wait_d ? ctrl_i_stall_D : (useful && ctrl_i_stall_D);
      p_rst      = rst;
      p_redirect = ctrl_i_redirect;
      p_stall    = ctrl_i_stall_D;
      p_useful   = useful;
      p_uaddr    = useful_addr;
      p_req      = imem_o_req;
      p_ack      = imem_i_ack;
      p_addr     = imem_o_addr;
      p_valid    = regD_o_valid;
      p_pc       = regD_o_pc;
      p_instr    = regD_o_instr;
      have_prev  = 1;
   end

endmodule
